mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL take parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; LAT, default 1, memory read latency in cycles (legal range 1..7).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request (level).
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetch data, valid when if_ack=1.
- dm_req  in  1  data-memory request (level).
- dm_we  in  1  1=store, 0=load.
- dm_be  in  4  store byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle data completion pulse.
- dm_rdata  out  DATA_W  load data, valid when dm_ack=1.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after mem_en.
- phase  out  1  owner of last granted access (0=IF, 1=DM).

Function
REQ-003 The block SHALL share one single-ported memory between the IF and DM requesters, with at most one access in flight.
REQ-004 The FSM SHALL have states IDLE and BUSY, plus a 3-bit latency counter cnt and an owner bit.
REQ-005 In IDLE with any request pending, the block SHALL grant in the same cycle: mem_en=1, memory outputs driven from the winner, owner and phase set to the winner, cnt loaded with LAT-1, state -> BUSY.
REQ-006 Arbitration SHALL be: only one requesting -> it wins; both requesting -> the requester NOT equal to phase wins (strict alternation, toggled per grant).
REQ-007 For IF grants, mem_we=0 and mem_be=4'b0000; for DM grants, mem_we=dm_we and mem_be=dm_be; mem_wdata=dm_wdata on DM grants, 0 otherwise.
REQ-008 While mem_en=0, mem_we and mem_be SHALL be 0.
REQ-009 In BUSY, cnt SHALL decrement each cycle; when cnt=0 the owner's ack SHALL be 1 for that cycle, and state -> IDLE.
REQ-010 if_rdata and dm_rdata SHALL equal mem_rdata combinationally in their ack cycle; dm_rdata is don't-care for stores.
REQ-011 Access latency SHALL be exactly LAT cycles from grant to ack; the next grant occurs no earlier than the cycle after ack, giving throughput of one access per LAT+1 cycles.
REQ-012 Requesters hold req, address and data stable until ack; a req still high in the cycle after ack is a new request.
REQ-013 A requester whose req drops before grant SHALL NOT be granted; requests deasserted during BUSY SHALL NOT abort the in-flight access.
REQ-014 if_ack and dm_ack SHALL never be 1 in the same cycle; neither requester SHALL wait more than one other access while continuously requesting.

Reset
REQ-015 When rst=0, the block SHALL asynchronously enter IDLE with cnt=0, owner=0, phase=1 (so IF wins the first contended grant), and all outputs 0.
REQ-016 Release of rst SHALL NOT by itself produce mem_en; an access in flight at reset assertion SHALL be dropped with no ack.

Verification
REQ-017 Reset then both req=1 in the same cycle, LAT=1 -> IF granted in cycle 0, if_ack in cycle 1, DM granted in cycle 2, dm_ack in cycle 3, phase 0 then 1.
REQ-018 DM store (dm_we=1, dm_be=4'b0011, addr=0x40, wdata=0xDEADBEEF) alone -> one mem_en cycle with mem_we=1, mem_be=4'b0011, mem_addr=0x40, dm_ack after LAT cycles.
REQ-019 IF and DM held high continuously for 20 accesses -> grants alternate IF/DM strictly, 10 acks each, no cycle with both acks.
REQ-020 LAT=3, single IF fetch with mem_rdata=0x00000013 in cycle t+3 -> if_ack=1 and if_rdata=0x00000013 only in cycle t+3.
REQ-021 rst driven low in cycle t+1 of a LAT=3 DM load -> outputs 0 immediately, no dm_ack, first post-reset access starts only on a new request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch port and a
// data-memory port. One access in flight at a time; contended grants
// alternate strictly between the two requesters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1      // memory read latency, 1..7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              phase
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter is loaded at grant and reaches zero in the ack cycle.
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;   // requester of the access in flight (0=IF, 1=DM)

    logic any_req;
    logic win_dm;
    logic grant;
    logic done;

    // When both request, the one that did not get the last grant wins.
    assign any_req = if_req | dm_req;
    assign win_dm  = dm_req & (~if_req | ~phase);

    // Grant and completion are gated by rst so every output drops to 0
    // the instant reset is asserted, before the state registers settle.
    assign grant = rst & (state == IDLE) & any_req;
    assign done  = rst & (state == BUSY) & (cnt == 3'd0);

    // Memory-side strobes come straight from the winner in the grant cycle;
    // read data is passed through only in the owner's ack cycle.
    always_comb begin
        mem_en    = grant;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant) begin
            mem_addr = win_dm ? dm_addr : if_addr;
            if (win_dm) begin
                mem_we    = dm_we;
                mem_be    = dm_be;
                mem_wdata = dm_wdata;
            end
        end
        if_ack   = done & ~owner;
        dm_ack   = done & owner;
        if_rdata = if_ack ? mem_rdata : '0;
        dm_rdata = dm_ack ? mem_rdata : '0;
    end

    // Two-state controller: IDLE grants, BUSY counts down the latency.
    // phase powers up as DM so that IF takes the first contended grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            owner <= 1'b0;
            phase <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                        owner <= win_dm;
                        phase <= win_dm;
                    end
                end
                BUSY: begin
                    if (cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=1 and a LAT=3 instance, a timestamp-based
// reference model compared every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        if_ack;
        logic [31:0] if_rdata;
        logic        dm_ack;
        logic [31:0] dm_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        phase;
    } out_t;

    // Model state: whether an access is outstanding, the cycle it was
    // granted, who owns it, whether it is a store, and the last winner.
    typedef struct {
        bit busy;
        int gcyc;
        bit owner;
        bit we;
        bit phase;
    } model_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    in_t  ia, ib;
    out_t oa, ob;

    logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_phase;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_phase;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    assign oa = {a_if_ack, a_if_rdata, a_dm_ack, a_dm_rdata, a_mem_en, a_mem_we,
                 a_mem_be, a_mem_addr, a_mem_wdata, a_phase};
    assign ob = {b_if_ack, b_if_rdata, b_dm_ack, b_dm_rdata, b_mem_en, b_mem_we,
                 b_mem_be, b_mem_addr, b_mem_wdata, b_phase};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(ia.if_req), .if_addr(ia.if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(ia.dm_req), .dm_we(ia.dm_we), .dm_be(ia.dm_be), .dm_addr(ia.dm_addr),
        .dm_wdata(ia.dm_wdata), .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(ia.mem_rdata), .phase(a_phase)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(ib.if_req), .if_addr(ib.if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(ib.dm_req), .dm_we(ib.dm_we), .dm_be(ib.dm_be), .dm_addr(ib.dm_addr),
        .dm_wdata(ib.dm_wdata), .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(ib.mem_rdata), .phase(b_phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: ack exactly LAT cycles after the grant cycle; a new
    // grant only when nothing is outstanding; contended grants go to the
    // requester that did not win last time.
    task automatic step(input model_t m, input int lat, input in_t i, input logic r,
                        input int c, output model_t mn, output out_t e, output bit dmr_ok);
        bit w;
        mn = m;
        e = '0;
        dmr_ok = 1'b0;
        e.phase = m.phase;
        if (!r) begin
            mn.busy = 1'b0;
            mn.owner = 1'b0;
            mn.phase = 1'b1;
            e.phase = 1'b1;
        end else if (m.busy) begin
            if (c - m.gcyc == lat) begin
                if (m.owner) begin
                    e.dm_ack = 1'b1;
                    e.dm_rdata = i.mem_rdata;
                    dmr_ok = !m.we;
                end else begin
                    e.if_ack = 1'b1;
                    e.if_rdata = i.mem_rdata;
                end
                mn.busy = 1'b0;
            end
        end else if (i.if_req || i.dm_req) begin
            w = (i.if_req && i.dm_req) ? !m.phase : i.dm_req;
            e.mem_en = 1'b1;
            e.mem_addr = w ? i.dm_addr : i.if_addr;
            if (w) begin
                e.mem_we = i.dm_we;
                e.mem_be = i.dm_be;
                e.mem_wdata = i.dm_wdata;
            end
            mn.busy = 1'b1;
            mn.gcyc = c;
            mn.owner = w;
            mn.we = w & i.dm_we;
            mn.phase = w;
        end
    endtask

    task automatic cmp(input string n, input out_t e, input out_t a, input bit dmr_ok);
        chk({n, "_mem_en"}, a.mem_en, e.mem_en);
        chk({n, "_mem_we"}, a.mem_we, e.mem_we);
        chk({n, "_mem_be"}, a.mem_be, e.mem_be);
        chk({n, "_if_ack"}, a.if_ack, e.if_ack);
        chk({n, "_dm_ack"}, a.dm_ack, e.dm_ack);
        chk({n, "_phase"},  a.phase,  e.phase);
        if (e.mem_en) begin
            chk({n, "_mem_addr"}, a.mem_addr, e.mem_addr);
            chk({n, "_mem_wdata"}, a.mem_wdata, e.mem_wdata);
        end
        if (e.if_ack) chk({n, "_if_rdata"}, a.if_rdata, e.if_rdata);
        if (e.dm_ack && dmr_ok) chk({n, "_dm_rdata"}, a.dm_rdata, e.dm_rdata);
    endtask

    model_t ma = '{busy: 1'b0, gcyc: 0, owner: 1'b0, we: 1'b0, phase: 1'b1};
    model_t mb = '{busy: 1'b0, gcyc: 0, owner: 1'b0, we: 1'b0, phase: 1'b1};

    // Single compare process: both instances against the model every cycle.
    always @(negedge clk) begin
        model_t na, nb;
        out_t   ea, eb;
        bit     da, db;
        step(ma, 1, ia, rst, cyc, na, ea, da);
        step(mb, 3, ib, rst, cyc, nb, eb, db);
        cmp("A", ea, oa, da);
        cmp("B", eb, ob, db);
        ma <= na;
        mb <= nb;
    end

    // Transaction log filled by run(), offsets relative to its first cycle.
    int          g_cyc[$];
    logic [31:0] g_addr[$];
    logic [31:0] g_wdata[$];
    logic        g_we[$];
    logic [3:0]  g_be[$];
    int          a_cyc[$];
    logic        a_who[$];
    logic        a_phase_q[$];
    logic [31:0] a_rdata[$];
    int          both_cnt;

    task automatic set_in(input bit sel, input bit ifr, input bit dmr, input logic [31:0] rd);
        if (sel) begin
            ib.if_req = ifr; ib.dm_req = dmr; ib.mem_rdata = rd;
        end else begin
            ia.if_req = ifr; ia.dm_req = dmr; ia.mem_rdata = rd;
        end
    endtask

    // Holds each requester's req high until it has collected its quota of
    // acks, dropping it in the cycle after its last ack.
    task automatic run(input bit sel, input int n_if, input int n_dm,
                       input int rd_at, input logic [31:0] rd_val);
        int   got_if = 0, got_dm = 0, start, off;
        bit   done = 1'b0;
        out_t o;
        g_cyc.delete(); g_addr.delete(); g_wdata.delete(); g_we.delete(); g_be.delete();
        a_cyc.delete(); a_who.delete(); a_phase_q.delete(); a_rdata.delete();
        both_cnt = 0;
        @(posedge clk); #1;
        start = cyc;
        set_in(sel, n_if > 0, n_dm > 0, (rd_at == 0) ? rd_val : 32'hC0DE0000);
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            off = cyc - start;
            o = sel ? ob : oa;
            if (o.mem_en) begin
                g_cyc.push_back(off); g_addr.push_back(o.mem_addr);
                g_wdata.push_back(o.mem_wdata); g_we.push_back(o.mem_we); g_be.push_back(o.mem_be);
            end
            if (o.if_ack && o.dm_ack) both_cnt++;
            if (o.if_ack) begin
                got_if++;
                a_cyc.push_back(off); a_who.push_back(1'b0);
                a_phase_q.push_back(o.phase); a_rdata.push_back(o.if_rdata);
            end
            if (o.dm_ack) begin
                got_dm++;
                a_cyc.push_back(off); a_who.push_back(1'b1);
                a_phase_q.push_back(o.phase); a_rdata.push_back(o.dm_rdata);
            end
            @(posedge clk); #1;
            off = cyc - start;
            done = (got_if >= n_if) && (got_dm >= n_dm);
            set_in(sel, got_if < n_if, got_dm < n_dm,
                   (off == rd_at) ? rd_val : (32'hC0DE0000 | 32'(off)));
        end
        chk("run_completed", done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, en_n, ack_at, dm_n, last;
        rst = 1'b0;
        ia = '0; ib = '0;
        ia.if_req = 1'b1; ia.dm_req = 1'b1;   // requests during reset must be ignored
        ia.if_addr = 32'h100; ia.dm_addr = 32'h200; ia.dm_wdata = 32'h11223344; ia.dm_be = 4'hF;

        // Reset state
        @(negedge clk);
        chk("rst_a_mem_en", oa.mem_en, 0);
        chk("rst_a_phase", oa.phase, 1);
        chk("rst_b_phase", ob.phase, 1);
        chk("rst_a_acks", {oa.if_ack, oa.dm_ack}, 0);
        @(posedge clk); #1;
        ia.if_req = 1'b0; ia.dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_no_mem_en", oa.mem_en, 0);

        // Contended start, LAT=1: IF at 0, ack 1; DM at 2, ack 3
        run(1'b0, 1, 1, -1, 32'h0);
        chk("017_ngrant", g_cyc.size(), 2);
        chk("017_g0", g_cyc[0], 0);
        chk("017_g1", g_cyc[1], 2);
        chk("017_g0_addr", g_addr[0], 32'h100);
        chk("017_g0_webe", {g_we[0], g_be[0]}, 0);
        chk("017_nack", a_cyc.size(), 2);
        chk("017_ack0", a_cyc[0], 1);
        chk("017_ack1", a_cyc[1], 3);
        chk("017_who", {a_who[0], a_who[1]}, 2'b01);
        chk("017_phase", {a_phase_q[0], a_phase_q[1]}, 2'b01);

        // Continuous contention: 20 accesses alternate IF/DM
        run(1'b0, 10, 10, -1, 32'h0);
        chk("019_nack", a_cyc.size(), 20);
        chk("019_both", both_cnt, 0);
        for (int k = 0; k < a_who.size(); k++) begin
            chk("019_who", a_who[k], 32'(k % 2));
            chk("019_phase", a_phase_q[k], 32'(k % 2));
        end
        last = (a_cyc.size() > 0) ? a_cyc[a_cyc.size() - 1] : -1;
        chk("019_last_ack", last, 39);

        // DM store alone on LAT=3
        ib.dm_we = 1'b1; ib.dm_be = 4'b0011; ib.dm_addr = 32'h40; ib.dm_wdata = 32'hDEADBEEF;
        run(1'b1, 0, 1, -1, 32'h0);
        chk("018_ngrant", g_cyc.size(), 1);
        chk("018_g_cyc", g_cyc[0], 0);
        chk("018_we", g_we[0], 1);
        chk("018_be", g_be[0], 4'b0011);
        chk("018_addr", g_addr[0], 32'h40);
        chk("018_wdata", g_wdata[0], 32'hDEADBEEF);
        chk("018_ack", a_cyc[0], 3);
        chk("018_who", a_who[0], 1);

        // IF fetch, LAT=3, data only present at t+3
        ib.if_addr = 32'h80;
        run(1'b1, 1, 0, 3, 32'h00000013);
        chk("020_nack", a_cyc.size(), 1);
        chk("020_ack", a_cyc[0], 3);
        chk("020_rdata", a_rdata[0], 32'h00000013);
        chk("020_who", a_who[0], 0);

        // IF drops req mid-access (still completes); DM pulses req while busy (never granted)
        ib.if_addr = 32'h84; ib.dm_we = 1'b0;
        en_n = 0; ack_at = -1; dm_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            ib.if_req = (k == 0); ib.dm_req = (k == 1); ib.mem_rdata = 32'h5A5A0000 | 32'(k);
            @(negedge clk);
            if (ob.mem_en) en_n++;
            if (ob.if_ack) ack_at = k;
            if (ob.dm_ack) dm_n++;
        end
        chk("013_grants", en_n, 1);
        chk("013_if_ack_at", ack_at, 3);
        chk("013_no_dm", dm_n, 0);

        // Reset during a LAT=3 DM load
        ib.dm_addr = 32'h44;
        @(posedge clk); #1;
        ib.dm_req = 1'b1;
        @(negedge clk);
        chk("021_grant", ob.mem_en, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("021_rst_mem_en", ob.mem_en, 0);
        chk("021_rst_dm_ack", ob.dm_ack, 0);
        chk("021_rst_phase", ob.phase, 1);
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ob.dm_ack || ob.mem_en) hits++;
            @(posedge clk); #1;
            if (k == 1) ib.dm_req = 1'b0;
            if (k == 2) rst = 1'b1;
        end
        chk("021_quiet", hits, 0);
        run(1'b1, 0, 1, -1, 32'h0);
        chk("021_new_grant", g_cyc.size(), 1);
        chk("021_new_ack", a_cyc[0], 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
